// File: rtl/hsv2rgb_pkg.sv
// Shared constants and helpers for the streaming HSV-to-RGB converter.
// Width-dependent constants are functions of the component width DATA_W.
package hsv2rgb_pkg;

  typedef enum logic [2:0] {
    SEC_0 = 3'd0,
    SEC_1 = 3'd1,
    SEC_2 = 3'd2,
    SEC_3 = 3'd3,
    SEC_4 = 3'd4,
    SEC_5 = 3'd5
  } sector_e;

  function automatic int sw_of(input int dw);
    return dw - 3;
  endfunction

  function automatic int sector_of(input int dw);
    return 1 << (dw - 3);
  endfunction

  // Hues at or above this value wrap back into sectors 0/1
  function automatic int hue_wrap_of(input int dw);
    return 6 * sector_of(dw);
  endfunction

  function automatic int lane_w(input int dw);
    return 3 * dw;
  endfunction

  function automatic int lane_lsb(input int dw, input int k);
    return 3 * dw * k;
  endfunction

endpackage

// File: rtl/hsv2rgb_stream_if.sv
// Valid/ready stream carrying PPC packed pixels of three DATA_W components
// plus a USER_W sideband.
interface hsv2rgb_stream_if #(
  parameter int DATA_W = 8,
  parameter int PPC    = 1,
  parameter int USER_W = 2
);

  logic [3*DATA_W*PPC-1:0] data;
  logic [USER_W-1:0]       user;
  logic                    valid;
  logic                    ready;

  modport master (output data, output user, output valid, input ready);
  modport slave  (input data, input user, input valid, output ready);

endinterface

// File: rtl/hsv2rgb_lane.sv
// One pixel's 4-stage HSV-to-RGB datapath, advancing only when ce is high.
// Define HSV2RGB_ROUND_EN for round-half-up on the two scaling shifts.
module hsv2rgb_lane
  import hsv2rgb_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ce,
  input  logic [DATA_W-1:0] h,
  input  logic [DATA_W-1:0] s,
  input  logic [DATA_W-1:0] v,
  output logic [DATA_W-1:0] r,
  output logic [DATA_W-1:0] g,
  output logic [DATA_W-1:0] b
);

  localparam int SW       = sw_of(DATA_W);
  localparam int SECTOR   = sector_of(DATA_W);
  localparam int HUE_WRAP = hue_wrap_of(DATA_W);
  localparam int PW       = 3*DATA_W - 2;
  localparam int TW       = DATA_W + 2;

  logic [DATA_W-1:0]   hw;
  logic [SW-1:0]       frac;
  logic [SW:0]         f_c;
  sector_e             n_c;
  logic [DATA_W-1:0]   diff;
  logic [TW-1:0]       term;
  logic [TW-1:0]       med_sum;
  logic [DATA_W-1:0]   med_c;

  sector_e             n1, n2, n3;
  logic [SW:0]         f1;
  logic [2*DATA_W-1:0] sv1;
  logic [DATA_W-1:0]   max1, max2, max3;
  logic [DATA_W-1:0]   min2, min3, med3;
  logic [PW-1:0]       p2;

  // Falling sectors measure f from the end of the sector so f spans 0..SECTOR
  always_comb begin
    hw   = (h >= DATA_W'(HUE_WRAP)) ? h - DATA_W'(HUE_WRAP) : h;
    n_c  = sector_e'(hw[DATA_W-1:SW]);
    frac = hw[SW-1:0];
    f_c  = hw[SW] ? (SW+1)'(SECTOR) - {1'b0, frac} : {1'b0, frac};
  end

  always_comb begin
`ifdef HSV2RGB_ROUND_EN
    diff = DATA_W'(((DATA_W+1)'(({1'b0, sv1} + ((2*DATA_W+1)'(1) << (DATA_W-1))) >> DATA_W) > {1'b0, max1})
           ? max1
           : DATA_W'(({1'b0, sv1} + ((2*DATA_W+1)'(1) << (DATA_W-1))) >> DATA_W);
    term = TW'(({1'b0, p2} + ((PW+1)'(1) << (DATA_W+SW-1))) >> (DATA_W+SW));
`else
    diff = DATA_W'(sv1 >> DATA_W);
    term = TW'(p2 >> (DATA_W+SW));
`endif
    med_sum = TW'(min2) + term;
    med_c   = (med_sum > TW'(max2)) ? max2 : med_sum[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      n1   <= SEC_0;
      f1   <= '0;
      sv1  <= '0;
      max1 <= '0;
      n2   <= SEC_0;
      min2 <= '0;
      max2 <= '0;
      p2   <= '0;
      n3   <= SEC_0;
      min3 <= '0;
      max3 <= '0;
      med3 <= '0;
    end else if (ce) begin
      n1   <= n_c;
      f1   <= f_c;
      sv1  <= (2*DATA_W)'(s) * (2*DATA_W)'(v);
      max1 <= v;
      n2   <= n1;
      min2 <= max1 - diff;
      max2 <= max1;
      p2   <= PW'(f1) * PW'(sv1);
      n3   <= n2;
      min3 <= min2;
      max3 <= max2;
      med3 <= med_c;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r <= '0;
      g <= '0;
      b <= '0;
    end else if (ce) begin
      case (n3)
        SEC_0:   begin r <= max3; g <= med3; b <= min3; end
        SEC_1:   begin r <= med3; g <= max3; b <= min3; end
        SEC_2:   begin r <= min3; g <= max3; b <= med3; end
        SEC_3:   begin r <= min3; g <= med3; b <= max3; end
        SEC_4:   begin r <= med3; g <= min3; b <= max3; end
        default: begin r <= max3; g <= min3; b <= med3; end
      endcase
    end
  end

endmodule

// File: rtl/hsv2rgb_stream.sv
// Streaming HSV-to-RGB converter: PPC parallel lanes, 4-cycle latency, global stall.
// Rounding of the internal shifts is selected by HSV2RGB_ROUND_EN.
module hsv2rgb_stream
  import hsv2rgb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PPC    = 1,
  parameter int USER_W = 2
) (
  input  logic clk,
  input  logic resetn,
  hsv2rgb_stream_if.slave  hsv_s,
  hsv2rgb_stream_if.master rgb_m
);

  localparam int LW = lane_w(DATA_W);

  logic                ce;
  logic [3:0]          vld;
  logic [USER_W-1:0]   usr [4];
  logic [DATA_W-1:0]   r_l [PPC];
  logic [DATA_W-1:0]   g_l [PPC];
  logic [DATA_W-1:0]   b_l [PPC];
  logic [LW*PPC-1:0]   rgb_data;

  // The whole pipeline freezes only when a finished beat is waiting downstream
  assign ce          = rgb_m.ready | ~vld[3];
  assign hsv_s.ready = ce;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld <= '0;
      for (int i = 0; i < 4; i++) usr[i] <= '0;
    end else if (ce) begin
      vld    <= {vld[2:0], hsv_s.valid};
      usr[0] <= hsv_s.user;
      for (int i = 1; i < 4; i++) usr[i] <= usr[i-1];
    end
  end

  for (genvar k = 0; k < PPC; k++) begin : g_lane
    hsv2rgb_lane #(.DATA_W(DATA_W)) u_lane (
      .clk    (clk),
      .resetn (resetn),
      .ce     (ce),
      .h      (hsv_s.data[lane_lsb(DATA_W, k) + 3*DATA_W - 1 -: DATA_W]),
      .s      (hsv_s.data[lane_lsb(DATA_W, k) + 2*DATA_W - 1 -: DATA_W]),
      .v      (hsv_s.data[lane_lsb(DATA_W, k) + DATA_W - 1 -: DATA_W]),
      .r      (r_l[k]),
      .g      (g_l[k]),
      .b      (b_l[k])
    );
  end

  always_comb begin
    rgb_data = '0;
    for (int k = 0; k < PPC; k++) rgb_data[LW*k +: LW] = {r_l[k], g_l[k], b_l[k]};
  end

  assign rgb_m.data  = rgb_data;
  assign rgb_m.valid = vld[3];
  assign rgb_m.user  = usr[3];

endmodule

// File: tb/tb_hsv2rgb_stream.sv
// Directed bench for hsv2rgb_stream: vector table, back-to-back, backpressure,
// async reset with beats in flight, and a 4-lane instance.
module tb_hsv2rgb_stream;

  typedef struct {
    logic [7:0] h, s, v, r, g, b;
  } vec_t;

`ifdef HSV2RGB_ROUND_EN
  localparam logic [7:0] G_WRAP = 8'd65;
  localparam logic [7:0] R_H255 = 8'd9;
`else
  localparam logic [7:0] G_WRAP = 8'd64;
  localparam logic [7:0] R_H255 = 8'd8;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  logic [25:0] got_q[$];
  int          got_cyc[$];
  int          in_cyc[$];
  vec_t        vecs[13];

  hsv2rgb_stream_if #(.DATA_W(8), .PPC(1), .USER_W(2)) hsv_if ();
  hsv2rgb_stream_if #(.DATA_W(8), .PPC(1), .USER_W(2)) rgb_if ();
  hsv2rgb_stream_if #(.DATA_W(8), .PPC(4), .USER_W(2)) hsv4_if ();
  hsv2rgb_stream_if #(.DATA_W(8), .PPC(4), .USER_W(2)) rgb4_if ();

  hsv2rgb_stream #(.DATA_W(8), .PPC(1), .USER_W(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .hsv_s  (hsv_if),
    .rgb_m  (rgb_if)
  );

  hsv2rgb_stream #(.DATA_W(8), .PPC(4), .USER_W(2)) dut4 (
    .clk    (clk),
    .resetn (resetn),
    .hsv_s  (hsv4_if),
    .rgb_m  (rgb4_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Transfers are recorded at the falling edge, where handshake signals are settled
  always @(negedge clk) begin
    if (resetn && rgb_if.valid && rgb_if.ready) begin
      got_q.push_back({rgb_if.user, rgb_if.data});
      got_cyc.push_back(cyc);
    end
    if (resetn && hsv_if.valid && hsv_if.ready) in_cyc.push_back(cyc);
  end

  task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] h, input logic [7:0] s, input logic [7:0] v,
                               input logic [1:0] user);
    bit taken;
    taken = 1'b0;
    hsv_if.data  = {h, s, v};
    hsv_if.user  = user;
    hsv_if.valid = 1'b1;
    for (int t = 0; t < 100 && !taken; t++) begin
      @(negedge clk);
      taken = hsv_if.ready;
      @(posedge clk);
      #2;
    end
    hsv_if.valid = 1'b0;
    if (!taken) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic waitOutputs(input int n);
    int budget;
    budget = 0;
    do begin
      @(posedge clk);
      budget++;
    end while (got_q.size() < n && budget < 200);
    #2;
    if (got_q.size() < n) checkOutput("output_timeout", got_q.size(), n);
  endtask

  function automatic logic [25:0] gotAt(input int i);
    if (i < got_q.size()) return got_q[i];
    return 'x;
  endfunction

  function automatic int latencyOf0();
    if (got_cyc.size() > 0 && in_cyc.size() > 0) return got_cyc[0] - in_cyc[0];
    return -1;
  endfunction

  task automatic clearQueues();
    got_q.delete();
    got_cyc.delete();
    in_cyc.delete();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{8'd0,   8'd255, 8'd255, 8'd255,  8'd1,   8'd1};
    vecs[1]  = '{8'd32,  8'd255, 8'd255, 8'd255,  8'd255, 8'd1};
    vecs[2]  = '{8'd64,  8'd255, 8'd255, 8'd1,    8'd255, 8'd1};
    vecs[3]  = '{8'd96,  8'd255, 8'd255, 8'd1,    8'd255, 8'd255};
    vecs[4]  = '{8'd128, 8'd255, 8'd255, 8'd1,    8'd1,   8'd255};
    vecs[5]  = '{8'd160, 8'd255, 8'd255, 8'd255,  8'd1,   8'd255};
    vecs[6]  = '{8'd100, 8'd0,   8'd128, 8'd128,  8'd128, 8'd128};
    vecs[7]  = '{8'd50,  8'd200, 8'd0,   8'd0,    8'd0,   8'd0};
    vecs[8]  = '{8'd200, 8'd255, 8'd255, 8'd255,  G_WRAP, 8'd1};
    vecs[9]  = '{8'd16,  8'd255, 8'd255, 8'd255,  8'd128, 8'd1};
    vecs[10] = '{8'd48,  8'd128, 8'd200, 8'd150,  8'd200, 8'd100};
    vecs[11] = '{8'd255, 8'd255, 8'd255, R_H255,  8'd255, 8'd1};
    vecs[12] = '{8'd192, 8'd255, 8'd255, 8'd255,  8'd1,   8'd1};

    hsv_if.data   = '0;
    hsv_if.user   = '0;
    hsv_if.valid  = 1'b0;
    rgb_if.ready  = 1'b1;
    hsv4_if.data  = '0;
    hsv4_if.user  = '0;
    hsv4_if.valid = 1'b0;
    rgb4_if.ready = 1'b1;

    #12;
    checkOutput("reset_valid", rgb_if.valid, 0);
    checkOutput("reset_data", rgb_if.data, 0);
    checkOutput("reset_user", rgb_if.user, 0);
    @(posedge clk);
    #2;
    resetn = 1'b1;
    checkOutput("reset_in_ready", hsv_if.ready, 1);

    for (int i = 0; i < 13; i++) begin
      clearQueues();
      applyStimulus(vecs[i].h, vecs[i].s, vecs[i].v, 2'(i));
      waitOutputs(1);
      checkOutput($sformatf("vec%0d_rgb", i), gotAt(0), {2'(i), vecs[i].r, vecs[i].g, vecs[i].b});
      checkOutput($sformatf("vec%0d_latency", i), latencyOf0(), 4);
      checkOutput($sformatf("vec%0d_valid_pulse", i), rgb_if.valid, 0);
    end

    clearQueues();
    applyStimulus(8'd32, 8'd255, 8'd255, 2'd1);
    applyStimulus(8'd64, 8'd255, 8'd255, 2'd2);
    waitOutputs(2);
    checkOutput("b2b_first", gotAt(0), {2'd1, 8'd255, 8'd255, 8'd1});
    checkOutput("b2b_second", gotAt(1), {2'd2, 8'd1, 8'd255, 8'd1});
    checkOutput("b2b_gap", (got_cyc.size() > 1) ? got_cyc[1] - got_cyc[0] : -1, 1);

    // Downstream stalls for 10 cycles while the second result sits at the output
    clearQueues();
    fork
      begin
        for (int i = 0; i < 6; i++) applyStimulus(vecs[i].h, vecs[i].s, vecs[i].v, 2'(i));
      end
      begin
        repeat (5) @(posedge clk);
        #2;
        rgb_if.ready = 1'b0;
        for (int j = 0; j < 10; j++) begin
          @(negedge clk);
          checkOutput($sformatf("stall%0d_in_ready", j), hsv_if.ready, 0);
          checkOutput($sformatf("stall%0d_hold", j), {rgb_if.valid, rgb_if.user, rgb_if.data},
                      {1'b1, 2'd1, 8'd255, 8'd255, 8'd1});
        end
        @(posedge clk);
        #2;
        rgb_if.ready = 1'b1;
      end
    join
    waitOutputs(6);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("bp_beat%0d", i), gotAt(i), {2'(i), vecs[i].r, vecs[i].g, vecs[i].b});
    repeat (8) @(posedge clk);
    #2;
    checkOutput("bp_count", got_q.size(), 6);

    hsv4_if.data  = 96'h60FFFF_40FFFF_20FFFF_00FFFF;
    hsv4_if.user  = 2'b10;
    hsv4_if.valid = 1'b1;
    @(negedge clk);
    checkOutput("ppc4_in_ready", hsv4_if.ready, 1);
    @(posedge clk);
    #2;
    hsv4_if.valid = 1'b0;
    for (int t = 0; t < 20 && !rgb4_if.valid; t++) begin
      @(posedge clk);
      #2;
    end
    checkOutput("ppc4_valid", rgb4_if.valid, 1);
    checkOutput("ppc4_lane0", rgb4_if.data[23:0], 24'hFF0101);
    checkOutput("ppc4_lane1", rgb4_if.data[47:24], 24'hFFFF01);
    checkOutput("ppc4_lane2", rgb4_if.data[71:48], 24'h01FF01);
    checkOutput("ppc4_lane3", rgb4_if.data[95:72], 24'h01FFFF);
    checkOutput("ppc4_user", rgb4_if.user, 2'b10);

    // Reset lands between clock edges while three beats are in flight
    clearQueues();
    rgb_if.ready = 1'b0;
    applyStimulus(vecs[3].h, vecs[3].s, vecs[3].v, 2'd3);
    applyStimulus(vecs[4].h, vecs[4].s, vecs[4].v, 2'd0);
    applyStimulus(vecs[5].h, vecs[5].s, vecs[5].v, 2'd1);
    repeat (2) @(posedge clk);
    #2;
    checkOutput("rst_pre_valid", rgb_if.valid, 1);
    #1;
    resetn = 1'b0;
    #1;
    checkOutput("rst_async_valid", rgb_if.valid, 0);
    checkOutput("rst_async_data", rgb_if.data, 0);
    checkOutput("rst_async_user", rgb_if.user, 0);
    @(posedge clk);
    #2;
    resetn = 1'b1;
    rgb_if.ready = 1'b1;
    checkOutput("rst_in_ready", hsv_if.ready, 1);
    repeat (10) @(posedge clk);
    #2;
    checkOutput("rst_no_stale", got_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
